rd_serial_rx: RTL and testbench

RD_SERIAL_RX -- requirements
Module: rd_serial_rx

---
 rtl/rd_serial_rx.sv | 205 ++++++++++++++++++++
 tb/tb_rd_serial_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_serial_rx.sv
// RD serial receiver: synchronises an asynchronous serial clock and NCHAN
// data lanes, deserialises parity-protected words into a buffered memory.
// Ports:
//   CLK120, RST_N        clock and synchronous active-low reset
//   SERIAL_CLK_IN/DATA   asynchronous serial clock and per-lane data
//   TRIG_IN, BUF_WNUM    trigger request and target buffer
//   CLR_FULL, CLR_NUM    clear status of a buffer
//   TRIG_OUT             stretched trigger to RD
//   ENABLE_MEM_WRT, DATA_ADDR, DATA_TO_MEM  memory write port
//   BUF_FULL, BUF_BUSY, PAR_ERR, TIMEOUT_ERR, MISSED_TRIG  status
module rd_serial_rx #(
    parameter int NCHAN      = 2,
    parameter int DW         = 12,
    parameter int NWORDS     = 8192,
    parameter int BUF_BITS   = 2,
    parameter int ODD_PARITY = 1,
    parameter int TIMEOUT    = 4095,
    parameter int TRIG_LEN   = 4,
    localparam int NBUF      = 2**BUF_BITS,
    localparam int WW        = $clog2(NWORDS),
    localparam int AW        = BUF_BITS + WW
) (
    input  logic                  CLK120,
    input  logic                  RST_N,
    input  logic                  SERIAL_CLK_IN,
    input  logic [NCHAN-1:0]      SERIAL_DATA_IN,
    input  logic                  TRIG_IN,
    input  logic [BUF_BITS-1:0]   BUF_WNUM,
    input  logic                  CLR_FULL,
    input  logic [BUF_BITS-1:0]   CLR_NUM,
    output logic                  TRIG_OUT,
    output logic                  ENABLE_MEM_WRT,
    output logic [AW-1:0]         DATA_ADDR,
    output logic [16*NCHAN-1:0]   DATA_TO_MEM,
    output logic [NBUF-1:0]       BUF_FULL,
    output logic [NBUF-1:0]       BUF_BUSY,
    output logic [NBUF*NCHAN-1:0] PAR_ERR,
    output logic [NBUF-1:0]       TIMEOUT_ERR,
    output logic [7:0]            MISSED_TRIG
);

    localparam int BW = $clog2(DW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(TRIG_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_DONE} state_t;

    state_t state_q, state_d;

    // sclk_q[0..1] synchroniser, sclk_q[2] previous synced value
    logic [2:0]                       sclk_q;
    logic [NCHAN-1:0]                 sd1_q, sd2_q;
    logic [BUF_BITS-1:0]              buf_q;
    logic [BW-1:0]                    bit_q;
    logic [WW-1:0]                    idx_q;
    logic [TW-1:0]                    to_q;
    logic [NCHAN-1:0][DW-1:0]         shreg_q;
    logic [NCHAN-1:0]                 par_q;
    logic [LW-1:0]                    trig_cnt_q;
    logic [7:0]                       missed_q;
    logic                             wr_q;
    logic [AW-1:0]                    addr_q;
    logic [16*NCHAN-1:0]              dout_q;
    logic [NBUF-1:0]                  full_q, busy_q, toerr_q;
    logic [NBUF-1:0][NCHAN-1:0]       perr_q;

    logic                             sedge, active, accept, rej;
    logic                             last_bit, word_end, last_word, tmo;
    logic [NCHAN-1:0]                 perr_new, perr_base;
    logic [16*NCHAN-1:0]              wdata;

    assign sedge     = sclk_q[1] & ~sclk_q[2];
    assign active    = (state_q == S_ARMED) || (state_q == S_RECV);
    assign accept    = TRIG_IN && (state_q == S_IDLE) && !full_q[BUF_WNUM];
    assign rej       = TRIG_IN && !accept;
    assign last_bit  = (bit_q == BW'(DW));
    assign word_end  = active && sedge && last_bit;
    assign last_word = (idx_q == WW'(NWORDS - 1));
    assign tmo       = active && !sedge && (to_q == TW'(TIMEOUT));

    // Accumulated data parity xor the parity bit gives the word parity
    assign perr_new  = par_q ^ sd2_q ^ {NCHAN{ODD_PARITY != 0}};
    // A clear and a new error in the same cycle keep the new error
    assign perr_base = (CLR_FULL && CLR_NUM == buf_q) ? '0 : perr_q[buf_q];

    always_comb begin
        wdata = '0;
        for (int c = 0; c < NCHAN; c++) begin
            wdata[16*c +: 16] = 16'(shreg_q[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ARMED;
            S_ARMED: begin
                if (sedge)    state_d = S_RECV;
                else if (tmo) state_d = S_IDLE;
            end
            S_RECV: begin
                if (word_end && last_word) state_d = S_DONE;
                else if (tmo)              state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK120) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK120) begin
        if (!RST_N) begin
            sclk_q     <= '0;
            sd1_q      <= '0;
            sd2_q      <= '0;
            buf_q      <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            to_q       <= '0;
            shreg_q    <= '0;
            par_q      <= '0;
            trig_cnt_q <= '0;
            missed_q   <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            full_q     <= '0;
            busy_q     <= '0;
            toerr_q    <= '0;
            perr_q     <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], SERIAL_CLK_IN};
            sd1_q  <= SERIAL_DATA_IN;
            sd2_q  <= sd1_q;
            wr_q   <= 1'b0;

            if (trig_cnt_q != '0) trig_cnt_q <= trig_cnt_q - 1'b1;
            if (rej && missed_q != 8'hFF) missed_q <= missed_q + 8'd1;

            if (CLR_FULL) begin
                full_q[CLR_NUM]  <= 1'b0;
                perr_q[CLR_NUM]  <= '0;
                toerr_q[CLR_NUM] <= 1'b0;
            end

            if (accept) begin
                buf_q             <= BUF_WNUM;
                perr_q[BUF_WNUM]  <= '0;
                toerr_q[BUF_WNUM] <= 1'b0;
                busy_q[BUF_WNUM]  <= 1'b1;
                trig_cnt_q        <= LW'(TRIG_LEN);
                bit_q             <= '0;
                idx_q             <= '0;
                to_q              <= '0;
                par_q             <= '0;
            end

            if (active) begin
                if (sedge) begin
                    to_q <= '0;
                    if (last_bit) begin
                        perr_q[buf_q] <= perr_base | perr_new;
                        wr_q          <= 1'b1;
                        addr_q        <= {buf_q, idx_q};
                        dout_q        <= wdata;
                        idx_q         <= idx_q + 1'b1;
                        bit_q         <= '0;
                        par_q         <= '0;
                    end else begin
                        for (int c = 0; c < NCHAN; c++) begin
                            shreg_q[c] <= DW'({shreg_q[c], sd2_q[c]});
                        end
                        par_q <= par_q ^ sd2_q;
                        bit_q <= bit_q + 1'b1;
                    end
                end else if (tmo) begin
                    toerr_q[buf_q] <= 1'b1;
                    busy_q[buf_q]  <= 1'b0;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end

            if (state_q == S_DONE) begin
                full_q[buf_q] <= 1'b1;
                busy_q[buf_q] <= 1'b0;
            end
        end
    end

    assign TRIG_OUT       = (trig_cnt_q != '0);
    assign ENABLE_MEM_WRT = wr_q;
    assign DATA_ADDR      = addr_q;
    assign DATA_TO_MEM    = dout_q;
    assign BUF_FULL       = full_q;
    assign BUF_BUSY       = busy_q;
    assign PAR_ERR        = perr_q;
    assign TIMEOUT_ERR    = toerr_q;
    assign MISSED_TRIG    = missed_q;

endmodule

// File: tb/tb_rd_serial_rx.sv
// Testbench for rd_serial_rx: directed and random transfers checked
// against a transfer-level model of writes and buffer status.
module tb_rd_serial_rx;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int NW  = 4;
    localparam int ODD = 0;
    localparam int TO  = 50;
    localparam int TL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic [1:0]  sdat = '0;
    logic        trig = 1'b0;
    logic [1:0]  wnum = '0;
    logic        clr = 1'b0;
    logic [1:0]  cnum = '0;
    logic        trig_out, en;
    logic [3:0]  addr;
    logic [31:0] dmem;
    logic [3:0]  full, busy, toerr;
    logic [7:0]  perr, missed;

    rd_serial_rx #(
        .NCHAN(NCH), .DW(DW), .NWORDS(NW), .BUF_BITS(2),
        .ODD_PARITY(ODD), .TIMEOUT(TO), .TRIG_LEN(TL)
    ) dut (
        .CLK120(clk), .RST_N(rst_n),
        .SERIAL_CLK_IN(sclk), .SERIAL_DATA_IN(sdat),
        .TRIG_IN(trig), .BUF_WNUM(wnum),
        .CLR_FULL(clr), .CLR_NUM(cnum),
        .TRIG_OUT(trig_out), .ENABLE_MEM_WRT(en),
        .DATA_ADDR(addr), .DATA_TO_MEM(dmem),
        .BUF_FULL(full), .BUF_BUSY(busy), .PAR_ERR(perr),
        .TIMEOUT_ERR(toerr), .MISSED_TRIG(missed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int          trig_hi = 0;
    logic [3:0]  wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (trig_out) trig_hi++;
        if (en) begin
            wa.push_back(addr);
            wd.push_back(dmem);
        end
    end

    logic [3:0]  m_full = '0;
    logic [7:0]  m_perr = '0;
    logic [3:0]  m_toerr = '0;
    int          m_missed = 0;

    logic [11:0] w0[NW];
    logic [11:0] w1[NW];
    logic        p0[NW];
    logic        p1[NW];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        n_chk++;
        assert (o === e)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic good_p(input logic [11:0] w);
        return (($countones(w) % 2) == 1) != (ODD == 1);
    endfunction

    function automatic logic bad_word(input logic [11:0] w,
                                      input logic p);
        return (($countones({w, p}) % 2) == 1) != (ODD == 1);
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic trigger(input logic [1:0] b);
        wnum = b;
        trig = 1'b1;
        tick;
        trig = 1'b0;
    endtask

    task automatic clear_buf(input logic [1:0] b);
        clr  = 1'b1;
        cnum = b;
        tick;
        clr  = 1'b0;
        tick;
        m_full[b]      = 1'b0;
        m_toerr[b]     = 1'b0;
        m_perr[2*b]    = 1'b0;
        m_perr[2*b+1]  = 1'b0;
    endtask

    task automatic send_bit(input logic [1:0] d);
        sdat = d;
        sclk = 1'b0;
        tick;
        tick;
        sclk = 1'b1;
        tick;
        tick;
    endtask

    task automatic run_xfer(input int nbits, input int clr_dly,
                            input int rej_at, input logic [1:0] b);
        int   total;
        bit   found;
        logic [1:0] d;
        total = 0;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k <= DW; k++) begin
                if (total >= nbits) return;
                if (total == rej_at) trigger(b);
                if (k < DW) d = {w1[w][DW-1-k], w0[w][DW-1-k]};
                else        d = {p1[w], p0[w]};
                if (w == NW - 1 && k == DW) begin
                    sdat = d;
                    sclk = 1'b0;
                    tick;
                    tick;
                    sclk = 1'b1;
                    found = 1'b0;
                    for (int n = 0; n < 10 && !found; n++) begin
                        tick;
                        if (en) found = 1'b1;
                    end
                    chk("last_write_seen", found, 1'b1);
                    if (clr_dly >= 0) begin
                        repeat (clr_dly) tick;
                        clr  = 1'b1;
                        cnum = b;
                        tick;
                        clr  = 1'b0;
                    end
                end else begin
                    send_bit(d);
                end
                total++;
            end
        end
    endtask

    task automatic do_xfer(input logic [1:0] b, input int clr_dly,
                           input int rej_at);
        int base;
        int t0;
        base = wa.size();
        t0   = trig_hi;
        trigger(b);
        chk("trig_out_start", trig_out, 1'b1);
        chk("busy_set", busy[b], 1'b1);
        run_xfer(NW * (DW + 1), clr_dly, rej_at, b);
        repeat (4) tick;
        if (rej_at >= 0) m_missed = sat(m_missed + 1);
        m_toerr[b] = 1'b0;
        m_perr[2*b]   = 1'b0;
        m_perr[2*b+1] = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (bad_word(w0[i], p0[i])) m_perr[2*b]   = 1'b1;
            if (bad_word(w1[i], p1[i])) m_perr[2*b+1] = 1'b1;
        end
        m_full[b] = 1'b1;
        if (clr_dly == 1) begin
            m_full[b]     = 1'b0;
            m_perr[2*b]   = 1'b0;
            m_perr[2*b+1] = 1'b0;
        end
        chk("n_writes", 64'(wa.size() - base), 64'(NW));
        for (int i = 0; i < NW; i++) begin
            if (base + i < wa.size()) begin
                chk("addr", wa[base+i], {b, 2'(i)});
                chk("data", wd[base+i], {4'h0, w1[i], 4'h0, w0[i]});
            end
        end
        chk("full", full, m_full);
        chk("busy", busy, 4'h0);
        chk("perr", perr, m_perr);
        chk("toerr", toerr, m_toerr);
        chk("missed", missed, 8'(m_missed));
        chk("trig_len", 64'(trig_hi - t0), 64'(TL));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_trig"},  trig_out, 1'b0);
        chk({tag, "_en"},    en, 1'b0);
        chk({tag, "_addr"},  addr, 4'h0);
        chk({tag, "_data"},  dmem, 32'h0);
        chk({tag, "_full"},  full, 4'h0);
        chk({tag, "_busy"},  busy, 4'h0);
        chk({tag, "_perr"},  perr, 8'h0);
        chk({tag, "_toerr"}, toerr, 4'h0);
        chk({tag, "_miss"},  missed, 8'h0);
    endtask

    task automatic fixed_words;
        for (int i = 0; i < NW; i++) begin
            w0[i] = 12'hABC;
            w1[i] = 12'h123;
            p0[i] = 1'b1;
            p1[i] = 1'b0;
        end
    endtask

    task automatic rand_words;
        for (int i = 0; i < NW; i++) begin
            w0[i] = 12'($urandom);
            w1[i] = 12'($urandom);
            p0[i] = good_p(w0[i]) ^ ($urandom_range(0, 5) == 0);
            p1[i] = good_p(w1[i]) ^ ($urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        int base;
        int t0;
        int k;
        logic [1:0] b;

        repeat (3) tick;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick;

        fixed_words();
        base = wa.size();
        do_xfer(2'd2, -1, -1);
        chk("basic_data", wd[base], 32'h01230ABC);
        chk("basic_full", full, 4'b0100);
        chk("basic_perr", perr, 8'h00);

        t0 = trig_hi;
        trigger(2'd2);
        repeat (6) tick;
        m_missed = sat(m_missed + 1);
        chk("rej_full_trig", 64'(trig_hi - t0), 64'd0);
        chk("rej_full_missed", missed, 8'(m_missed));

        clear_buf(2'd2);
        chk("clr_full", full, 4'b0000);
        p1[1] = ~p1[1];
        do_xfer(2'd2, -1, 20);
        chk("perr_bit5", perr, 8'h20);
        chk("missed_two", missed, 8'd2);

        clear_buf(2'd2);
        fixed_words();
        do_xfer(2'd2, 0, -1);
        chk("clr_same_cycle", full[2], 1'b1);
        clear_buf(2'd2);
        do_xfer(2'd2, 1, -1);
        chk("clr_next_cycle", full[2], 1'b0);

        repeat (6) begin
            b = 2'($urandom_range(0, 3));
            rand_words();
            if (m_full[b]) begin
                t0 = trig_hi;
                trigger(b);
                repeat (6) tick;
                m_missed = sat(m_missed + 1);
                chk("rnd_rej_trig", 64'(trig_hi - t0), 64'd0);
                chk("rnd_rej_missed", missed, 8'(m_missed));
                clear_buf(b);
            end
            do_xfer(b, -1, -1);
        end

        clear_buf(2'd3);
        rand_words();
        base = wa.size();
        trigger(2'd3);
        run_xfer(17, -1, -1, 2'd3);
        k = 0;
        while (!toerr[3] && k < 100) begin
            tick;
            k++;
        end
        m_toerr[3] = 1'b1;
        chk("to_seen", toerr, m_toerr);
        chk("to_latency", (k >= 40 && k <= 60), 1'b1);
        chk("to_busy", busy[3], 1'b0);
        chk("to_full", full[3], 1'b0);
        chk("to_writes", 64'(wa.size() - base), 64'd1);
        clear_buf(2'd1);
        rand_words();
        do_xfer(2'd1, -1, -1);

        clear_buf(2'd0);
        rand_words();
        trigger(2'd0);
        run_xfer(5, -1, -1, 2'd0);
        base = wa.size();
        rst_n = 1'b0;
        tick;
        check_zero("midrst");
        repeat (30) tick;
        chk("midrst_nowrite", 64'(wa.size() - base), 64'd0);
        rst_n = 1'b1;
        m_full = '0;
        m_perr = '0;
        m_toerr = '0;
        m_missed = 0;
        repeat (2) tick;
        rand_words();
        do_xfer(2'd0, -1, -1);

        repeat (254) trigger(2'd0);
        tick;
        chk("sat_254", missed, 8'd254);
        repeat (2) trigger(2'd0);
        tick;
        chk("sat_255", missed, 8'd255);
        repeat (3) trigger(2'd0);
        tick;
        chk("sat_hold", missed, 8'd255);
        chk("sat_full", full, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
